// File: rtl/calc_frame_ctrl.sv
// Request/response frame sequencer between the UART byte stream and the calculator ALU.
// Parses {cmd, op1, op2}, drives the ALU, and returns {status, result} over valid/ready.
module calc_frame_ctrl #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [1:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_error,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             rx_overrun,
    output logic             frame_timeout
);

    localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam bit          TO_EN   = (TIMEOUT_CYCLES > 0);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CNT_MAX);
    localparam logic [7:0]       ST_OK     = 8'h00;
    localparam logic [7:0]       ST_DIV0   = 8'h01;
    localparam logic [7:0]       ST_BADCMD = 8'h02;

    typedef enum logic [2:0] {
        IDLE,
        GET_OP1,
        GET_OP2,
        EXEC,
        SEND_STATUS,
        SEND_RESULT
    } state_t;

    state_t           state, state_n;
    logic [1:0]       opcode_n;
    logic [WIDTH-1:0] op1_n, op2_n;
    logic [WIDTH-1:0] result_q, result_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [7:0]       tx_data_n;
    logic             tx_valid_n;
    logic             busy_n;
    logic             overrun_n;
    logic             timeout_n;

    // State and every output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            alu_opcode    <= '0;
            alu_op1       <= '0;
            alu_op2       <= '0;
            result_q      <= '0;
            cnt_q         <= '0;
            tx_data       <= 8'h00;
            tx_valid      <= 1'b0;
            busy          <= 1'b0;
            rx_overrun    <= 1'b0;
            frame_timeout <= 1'b0;
        end else begin
            state         <= state_n;
            alu_opcode    <= opcode_n;
            alu_op1       <= op1_n;
            alu_op2       <= op2_n;
            result_q      <= result_n;
            cnt_q         <= cnt_n;
            tx_data       <= tx_data_n;
            tx_valid      <= tx_valid_n;
            busy          <= busy_n;
            rx_overrun    <= overrun_n;
            frame_timeout <= timeout_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n    = state;
        opcode_n   = alu_opcode;
        op1_n      = alu_op1;
        op2_n      = alu_op2;
        result_n   = result_q;
        cnt_n      = cnt_q;
        tx_data_n  = tx_data;
        tx_valid_n = tx_valid;
        overrun_n  = 1'b0;
        timeout_n  = 1'b0;

        case (state)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data[7:2] == 6'd0) begin
                        opcode_n = rx_data[1:0];
                        cnt_n    = '0;
                        state_n  = GET_OP1;
                    end else begin
                        tx_data_n  = ST_BADCMD;
                        result_n   = '0;
                        tx_valid_n = 1'b1;
                        state_n    = SEND_STATUS;
                    end
                end
            end
            GET_OP1: begin
                if (rx_valid) begin
                    op1_n   = WIDTH'(rx_data);
                    cnt_n   = '0;
                    state_n = GET_OP2;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    timeout_n = 1'b1;
                    state_n   = IDLE;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            GET_OP2: begin
                if (rx_valid) begin
                    op2_n   = WIDTH'(rx_data);
                    cnt_n   = '0;
                    state_n = EXEC;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    timeout_n = 1'b1;
                    state_n   = IDLE;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            EXEC: begin
                overrun_n  = rx_valid;
                tx_data_n  = alu_error ? ST_DIV0 : ST_OK;
                result_n   = alu_error ? '0 : alu_result;
                tx_valid_n = 1'b1;
                state_n    = SEND_STATUS;
            end
            SEND_STATUS: begin
                overrun_n = rx_valid;
                if (tx_ready) begin
                    tx_data_n = 8'(result_q);
                    state_n   = SEND_RESULT;
                end
            end
            SEND_RESULT: begin
                overrun_n = rx_valid;
                if (tx_ready) begin
                    tx_valid_n = 1'b0;
                    state_n    = IDLE;
                end
            end
            default: begin
                tx_valid_n = 1'b0;
                state_n    = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_calc_frame_ctrl.sv
// Scoreboard bench for calc_frame_ctrl: driver pushes expected response bytes from a
// reference model, a negedge monitor pops and compares whatever the DUT transmits.
module tb_calc_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [1:0] alu_opcode;
    logic [7:0] alu_op1, alu_op2, alu_result;
    logic       alu_error;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       busy, rx_overrun, frame_timeout;

    calc_frame_ctrl #(.WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_result(alu_result), .alu_error(alu_error),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .rx_overrun(rx_overrun), .frame_timeout(frame_timeout)
    );

    always #5 clk = ~clk;

    // Combinational ALU stub standing in for the real calculator datapath
    logic signed [15:0] sa, sb, sr;
    always_comb begin
        sa        = {{8{alu_op1[7]}}, alu_op1};
        sb        = {{8{alu_op2[7]}}, alu_op2};
        sr        = '0;
        alu_error = 1'b0;
        case (alu_opcode)
            2'd0: sr = sa + sb;
            2'd1: sr = sa - sb;
            2'd2: sr = sa * sb;
            default: begin
                if (sb == 16'sd0) alu_error = 1'b1;
                else              sr = sa / sb;
            end
        endcase
        alu_result = sr[7:0];
    end

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    int         exp_rise_q[$];
    int         exp_ovr = 0, exp_to = 0;
    int         ovr_cnt = 0, to_cnt = 0;
    int         last_strobe = 0;
    bit         force_ready = 1'b0;
    bit         ready_val = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: response frame computed from the command rules with integer arithmetic
    task automatic ref_frame(input logic [7:0] cmd, input logic [7:0] a8, input logic [7:0] b8,
                             output logic [7:0] st, output logic [7:0] res);
        int a, b, r;
        a = $signed(a8);
        b = $signed(b8);
        st = 8'h00;
        r  = 0;
        if (cmd[7:2] != 6'd0) begin
            st = 8'h02;
        end else begin
            case (cmd[1:0])
                2'd0: r = a + b;
                2'd1: r = a - b;
                2'd2: r = a * b;
                default: if (b == 0) st = 8'h01; else r = a / b;
            endcase
        end
        res = 8'(r);
    endtask

    // tx_ready: random backpressure unless the driver forces a value
    always @(posedge clk) begin
        #2;
        tx_ready = force_ready ? ready_val : ($urandom_range(0, 3) != 0);
    end

    // Monitor / scoreboard
    bit         prev_valid = 0, prev_stall = 0, prev_to = 0;
    logic [7:0] prev_data = 8'h00;
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 0;
            prev_stall = 0;
            prev_to    = 0;
        end else begin
            if (prev_stall) begin
                check("tx_valid_hold", tx_valid, 1'b1);
                check("tx_data_hold", tx_data, prev_data);
            end
            if (tx_valid && !prev_valid) begin
                if (exp_rise_q.size() > 0) check("tx_first_valid_cycle", cyc, exp_rise_q.pop_front());
                else                       check("tx_spurious_valid", tx_valid, 1'b0);
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() > 0) check("tx_byte", tx_data, exp_q.pop_front());
                else                  check("tx_unexpected_byte", tx_valid, 1'b0);
            end
            if (rx_overrun) ovr_cnt++;
            if (frame_timeout) begin
                to_cnt++;
                if (prev_to) check("frame_timeout_width", frame_timeout, 1'b0);
            end
            prev_valid = tx_valid;
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            prev_to    = frame_timeout;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            rx_valid = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid    = 1'b1;
        rx_data     = b;
        last_strobe = cyc;
    endtask

    task automatic wait_idle(input bit inject);
        bit done = 0, injected = 0;
        int n = 0;
        while (!done && n < 300) begin
            @(posedge clk); #1;
            rx_valid = 1'b0;
            n++;
            if (!busy) done = 1;
            else if (inject && !injected && $urandom_range(0, 3) == 0) begin
                rx_valid = 1'b1;
                rx_data  = 8'($urandom);
                injected = 1;
                exp_ovr++;
            end
        end
        if (!done) check("wait_idle_budget", busy, 1'b0);
    endtask

    // Issue one request; a gap of 16+ idle cycles abandons the frame via timeout
    task automatic issue_frame(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] b,
                               input int g1, input int g2, output bit responds);
        logic [7:0] st, res;
        responds = 1'b0;
        send_byte(cmd);
        if (cmd[7:2] == 6'd0) begin
            if (g1 >= 16) begin
                idle(20); exp_to++; check("timeout_busy_low", busy, 1'b0); return;
            end
            idle(g1);
            send_byte(a);
            if (g2 >= 16) begin
                idle(20); exp_to++; check("timeout_busy_low", busy, 1'b0); return;
            end
            idle(g2);
            send_byte(b);
            exp_rise_q.push_back(last_strobe + 2);
        end else begin
            exp_rise_q.push_back(last_strobe + 1);
        end
        ref_frame(cmd, a, b, st, res);
        exp_q.push_back(st);
        exp_q.push_back(res);
        responds = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] b,
                              input int g1, input int g2, input bit inject);
        bit r;
        issue_frame(cmd, a, b, g1, g2, r);
        if (r) wait_idle(inject);
    endtask

    task automatic wait_tx_valid();
        int n = 0;
        while (!tx_valid && n < 20) begin
            @(posedge clk); #1;
            rx_valid = 1'b0;
            n++;
        end
        check("tx_valid_arrives", tx_valid, 1'b1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit r;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_alu", {alu_opcode, alu_op1, alu_op2}, 18'h0);
        check("rst_pulses", {rx_overrun, frame_timeout}, 2'b00);
        rst = 1'b0;

        send_frame(8'h00, 8'h05, 8'h03, 0, 0, 0);
        check("add_alu_opcode", alu_opcode, 2'b00);
        check("add_alu_op1", alu_op1, 8'h05);
        check("add_alu_op2", alu_op2, 8'h03);
        send_frame(8'h01, 8'h03, 8'h05, 1, 2, 0);
        send_frame(8'h02, 8'hFD, 8'h04, 0, 3, 0);
        send_frame(8'h03, 8'h07, 8'h00, 2, 0, 0);
        send_frame(8'h03, 8'h09, 8'hFD, 0, 0, 0);
        send_frame(8'h84, 8'h00, 8'h00, 0, 0, 0);
        check("badcmd_alu_held", {alu_opcode, alu_op1, alu_op2}, {2'b11, 8'h09, 8'hFD});
        send_frame(8'h00, 8'h01, 8'h01, 0, 0, 0);

        send_frame(8'h00, 8'h05, 8'h00, 0, 16, 0);
        send_frame(8'h02, 8'h10, 8'h03, 0, 0, 0);
        send_frame(8'h00, 8'h07, 8'h01, 15, 15, 0);

        // Backpressure stall with an overrun byte injected mid-stall
        force_ready = 1'b1;
        ready_val   = 1'b0;
        issue_frame(8'h00, 8'h11, 8'h22, 0, 0, r);
        wait_tx_valid();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            rx_valid = 1'b0;
            check("stall_tx_valid", tx_valid, 1'b1);
            check("stall_tx_data", tx_data, 8'h00);
            if (i == 4) check("stall_rx_overrun", rx_overrun, 1'b1);
            if (i == 3) begin
                rx_valid = 1'b1;
                rx_data  = 8'h00;
                exp_ovr++;
            end
        end
        force_ready = 1'b0;
        wait_idle(0);
        idle(3);
        check("overrun_byte_ignored", busy, 1'b0);

        // Reset in the middle of SEND_RESULT
        force_ready = 1'b1;
        ready_val   = 1'b0;
        issue_frame(8'h00, 8'h02, 8'h02, 0, 0, r);
        wait_tx_valid();
        ready_val = 1'b1;
        @(posedge clk); #1;
        ready_val = 1'b0;
        #2;
        check("send_result_valid", tx_valid, 1'b1);
        check("send_result_data", tx_data, 8'h04);
        exp_q.delete();
        exp_rise_q.delete();
        rst = 1'b1;
        #1;
        check("midrst_tx", {tx_valid, tx_data}, 9'h0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_alu", {alu_opcode, alu_op1, alu_op2}, 18'h0);
        repeat (2) @(posedge clk);
        #1;
        rst         = 1'b0;
        force_ready = 1'b0;
        check("post_rst_busy", busy, 1'b0);

        for (int f = 0; f < 60; f++) begin
            logic [7:0] cmd;
            int         g[2];
            cmd = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
            for (int k = 0; k < 2; k++) begin
                int sel;
                sel  = $urandom_range(0, 19);
                g[k] = (sel == 12) ? 15 : (sel == 13) ? 16 : $urandom_range(0, 3);
            end
            send_frame(cmd, 8'($urandom), 8'($urandom), g[0], g[1], 1'b1);
        end

        idle(5);
        check("overrun_pulse_count", ovr_cnt, exp_ovr);
        check("timeout_pulse_count", to_cnt, exp_to);
        check("tx_bytes_outstanding", exp_q.size(), 0);
        check("tx_frames_outstanding", exp_rise_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
